// File: rtl/disp_cmd_pkg.sv
// Shared definitions for the display command controller: opcodes, FSM states,
// reset colours and the packed layout of a buffered command.
package disp_cmd_pkg;

  localparam logic [3:0] OP_MODE    = 4'd1;
  localparam logic [3:0] OP_FG      = 4'd2;
  localparam logic [3:0] OP_BG      = 4'd3;
  localparam logic [3:0] OP_PATTERN = 4'd4;
  localparam logic [3:0] OP_BLANK   = 4'd5;

  localparam int ENTRY_W = 15;

  localparam logic [11:0] FG_RST = 12'hFFF;
  localparam logic [11:0] BG_RST = 12'h000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_APPLY
  } state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [11:0] arg;
  } entry_t;

  // The check nibble must be the bitwise inverse of the opcode.
  function automatic logic cmd_valid(input logic [3:0] op, input logic [3:0] chk);
    return (chk == ~op) && (op >= OP_MODE) && (op <= OP_BLANK);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO holding pending display commands. The caller must only push
// when not full, or when popping in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wr_data,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: storage is deliberately not reset; count guarantees stale words are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/disp_cmd_ctrl.sv
// Decodes UART command words, buffers them, and applies them to the display
// configuration registers only at frame boundaries.
module disp_cmd_ctrl
  import disp_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [31:0]      data,
  input  logic             s_flag,
  input  logic             frame_start,
  output logic             mode,
  output logic             mode_chg,
  output logic [2:0]       pattern,
  output logic [11:0]      fg_rgb,
  output logic [11:0]      bg_rgb,
  output logic             blank,
  output logic             pending,
  output logic             cmd_err,
  output logic [CNT_W-1:0] rej_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state, state_next;
  entry_t        wr_entry, rd_entry;
  logic          word_ok, push, pop, drop, full, empty, go;
  logic [CW-1:0] count, apply_left;
  logic          unused_bits;

  assign word_ok     = cmd_valid(data[31:28], data[27:24]);
  assign wr_entry    = '{op: data[30:28], arg: data[11:0]};
  assign pop         = (state == ST_APPLY);
  assign push        = s_flag && word_ok && (!full || pop);
  assign drop        = s_flag && !push;
  assign pending     = !empty;
  assign unused_bits = ^data[23:12];

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // The count is snapshotted at the frame boundary; go delays APPLY by one cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      go         <= 1'b0;
      apply_left <= '0;
    end else begin
      state <= state_next;
      go    <= (state == ST_WAIT_FRAME) && frame_start;
      if ((state == ST_WAIT_FRAME) && frame_start) apply_left <= count;
      else if (pop)                                apply_left <= apply_left - 1'b1;
    end
  end

  // NOTE: next-state gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (push) state_next = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (go)   state_next = ST_APPLY;
      ST_APPLY:
        if (apply_left == CW'(1))
          state_next = (count == CW'(1) && !push) ? ST_IDLE : ST_WAIT_FRAME;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode     <= 1'b0;
      mode_chg <= 1'b0;
      pattern  <= '0;
      fg_rgb   <= FG_RST;
      bg_rgb   <= BG_RST;
      blank    <= 1'b0;
    end else begin
      mode_chg <= 1'b0;
      if (pop) begin
        case ({1'b0, rd_entry.op})
          OP_MODE: begin
            mode     <= rd_entry.arg[0];
            mode_chg <= (rd_entry.arg[0] != mode);
          end
          OP_FG:      fg_rgb  <= rd_entry.arg;
          OP_BG:      bg_rgb  <= rd_entry.arg;
          OP_PATTERN: pattern <= rd_entry.arg[2:0];
          OP_BLANK:   blank   <= rd_entry.arg[0];
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_err <= 1'b0;
      rej_cnt <= '0;
    end else begin
      cmd_err <= drop;
      if (drop && (rej_cnt != '1)) rej_cnt <= rej_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_disp_cmd_ctrl.sv
// Table-driven bench for disp_cmd_ctrl, plus directed sequences for overflow,
// push-during-apply, counter saturation and reset in the middle of a drain.
module tb_disp_cmd_ctrl;

  typedef struct packed {
    logic        mode;
    logic        chg;
    logic [2:0]  pat;
    logic [11:0] fg;
    logic [11:0] bg;
    logic        blank;
    logic        pend;
    logic        err;
    logic [7:0]  rej;
  } outs_t;

  typedef struct {
    logic [31:0] data;
    logic        sf;
    logic        fs;
    outs_t       exp;
  } vec_t;

  logic        sys_clk, sys_rst_n;
  logic [31:0] data;
  logic        s_flag, frame_start;
  logic        mode, mode_chg, blank, pending, cmd_err;
  logic [2:0]  pattern;
  logic [11:0] fg_rgb, bg_rgb;
  logic [7:0]  rej_cnt;

  int checks = 0;
  int errors = 0;

  disp_cmd_ctrl #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .data        (data),
    .s_flag      (s_flag),
    .frame_start (frame_start),
    .mode        (mode),
    .mode_chg    (mode_chg),
    .pattern     (pattern),
    .fg_rgb      (fg_rgb),
    .bg_rgb      (bg_rgb),
    .blank       (blank),
    .pending     (pending),
    .cmd_err     (cmd_err),
    .rej_cnt     (rej_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic outs_t mk(input logic m, input logic c, input logic [2:0] p,
                               input logic [11:0] f, input logic [11:0] b,
                               input logic bl, input logic pe, input logic er,
                               input logic [7:0] rj);
    return '{mode: m, chg: c, pat: p, fg: f, bg: b, blank: bl, pend: pe, err: er, rej: rj};
  endfunction

  function automatic vec_t v(input logic [31:0] d, input logic sf, input logic fs,
                             input outs_t e);
    vec_t r;
    r.data = d; r.sf = sf; r.fs = fs; r.exp = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input outs_t e);
    check({tag, ".mode"},     32'(mode),     32'(e.mode));
    check({tag, ".mode_chg"}, 32'(mode_chg), 32'(e.chg));
    check({tag, ".pattern"},  32'(pattern),  32'(e.pat));
    check({tag, ".fg_rgb"},   32'(fg_rgb),   32'(e.fg));
    check({tag, ".bg_rgb"},   32'(bg_rgb),   32'(e.bg));
    check({tag, ".blank"},    32'(blank),    32'(e.blank));
    check({tag, ".pending"},  32'(pending),  32'(e.pend));
    check({tag, ".cmd_err"},  32'(cmd_err),  32'(e.err));
    check({tag, ".rej_cnt"},  32'(rej_cnt),  32'(e.rej));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic [31:0] d, input logic sf, input logic fs);
    data = d; s_flag = sf; frame_start = fs;
    @(posedge sys_clk);
    #1;
    data = '0; s_flag = 1'b0; frame_start = 1'b0;
  endtask

  vec_t  tbl[$];
  outs_t rst_o;

  initial begin
    sys_rst_n = 1'b0; data = '0; s_flag = 1'b0; frame_start = 1'b0;
    rst_o = mk(0, 0, 3'd0, 12'hFFF, 12'h000, 0, 0, 0, 8'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    check_outs("reset", rst_o);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Frame start with nothing buffered is ignored.
    tbl.push_back(v(32'h0, 0, 0, rst_o));
    tbl.push_back(v(32'h0, 0, 1, rst_o));
    tbl.push_back(v(32'h0, 0, 0, rst_o));
    // SET_FG F00: push, wait, frame at f, APPLY from f+1, visible after f+2.
    tbl.push_back(v(32'h2D00_0F00, 1, 0, mk(0, 0, 0, 12'hFFF, 0, 0, 1, 0, 0)));
    tbl.push_back(v(32'h0,         0, 0, mk(0, 0, 0, 12'hFFF, 0, 0, 1, 0, 0)));
    tbl.push_back(v(32'h0,         0, 1, mk(0, 0, 0, 12'hFFF, 0, 0, 1, 0, 0)));
    tbl.push_back(v(32'h0,         0, 0, mk(0, 0, 0, 12'hFFF, 0, 0, 1, 0, 0)));
    tbl.push_back(v(32'h0,         0, 0, mk(0, 0, 0, 12'hF00, 0, 0, 0, 0, 0)));
    tbl.push_back(v(32'h0,         0, 0, mk(0, 0, 0, 12'hF00, 0, 0, 0, 0, 0)));
    // SET_MODE 1 twice in one drain: one mode_chg pulse.
    tbl.push_back(v(32'h1E00_0001, 1, 0, mk(0, 0, 0, 12'hF00, 0, 0, 1, 0, 0)));
    tbl.push_back(v(32'h1E00_0001, 1, 0, mk(0, 0, 0, 12'hF00, 0, 0, 1, 0, 0)));
    tbl.push_back(v(32'h0,         0, 1, mk(0, 0, 0, 12'hF00, 0, 0, 1, 0, 0)));
    tbl.push_back(v(32'h0,         0, 0, mk(0, 0, 0, 12'hF00, 0, 0, 1, 0, 0)));
    tbl.push_back(v(32'h0,         0, 0, mk(1, 1, 0, 12'hF00, 0, 0, 1, 0, 0)));
    tbl.push_back(v(32'h0,         0, 0, mk(1, 0, 0, 12'hF00, 0, 0, 0, 0, 0)));
    tbl.push_back(v(32'h0,         0, 0, mk(1, 0, 0, 12'hF00, 0, 0, 0, 0, 0)));
    // Bad check nibble, then out-of-range opcode.
    tbl.push_back(v(32'h2000_0ABC, 1, 0, mk(1, 0, 0, 12'hF00, 0, 0, 0, 1, 1)));
    tbl.push_back(v(32'h0,         0, 0, mk(1, 0, 0, 12'hF00, 0, 0, 0, 0, 1)));
    tbl.push_back(v(32'h6900_0000, 1, 0, mk(1, 0, 0, 12'hF00, 0, 0, 0, 1, 2)));
    tbl.push_back(v(32'h0,         0, 0, mk(1, 0, 0, 12'hF00, 0, 0, 0, 0, 2)));
    tbl.push_back(v(32'h0,         0, 1, mk(1, 0, 0, 12'hF00, 0, 0, 0, 0, 2)));
    // Pattern, background, blank, mode back to 0, all in one drain of four.
    tbl.push_back(v(32'h4B00_0005, 1, 0, mk(1, 0, 0, 12'hF00, 12'h000, 0, 1, 0, 2)));
    tbl.push_back(v(32'h3C00_0123, 1, 0, mk(1, 0, 0, 12'hF00, 12'h000, 0, 1, 0, 2)));
    tbl.push_back(v(32'h5A00_0001, 1, 0, mk(1, 0, 0, 12'hF00, 12'h000, 0, 1, 0, 2)));
    tbl.push_back(v(32'h1E00_0000, 1, 0, mk(1, 0, 0, 12'hF00, 12'h000, 0, 1, 0, 2)));
    tbl.push_back(v(32'h0,         0, 1, mk(1, 0, 0, 12'hF00, 12'h000, 0, 1, 0, 2)));
    tbl.push_back(v(32'h0,         0, 0, mk(1, 0, 0, 12'hF00, 12'h000, 0, 1, 0, 2)));
    tbl.push_back(v(32'h0,         0, 0, mk(1, 0, 5, 12'hF00, 12'h000, 0, 1, 0, 2)));
    tbl.push_back(v(32'h0,         0, 0, mk(1, 0, 5, 12'hF00, 12'h123, 0, 1, 0, 2)));
    tbl.push_back(v(32'h0,         0, 0, mk(1, 0, 5, 12'hF00, 12'h123, 1, 1, 0, 2)));
    tbl.push_back(v(32'h0,         0, 0, mk(0, 1, 5, 12'hF00, 12'h123, 1, 0, 0, 2)));
    tbl.push_back(v(32'h0,         0, 0, mk(0, 0, 5, 12'hF00, 12'h123, 1, 0, 0, 2)));

    foreach (tbl[i]) begin
      step(tbl[i].data, tbl[i].sf, tbl[i].fs);
      check_outs($sformatf("row%0d", i), tbl[i].exp);
    end

    // Overflow: fifth push with a full FIFO and no frame is dropped.
    step(32'h2D00_0ABC, 1, 0);
    step(32'h3C00_0456, 1, 0);
    step(32'h4B00_0002, 1, 0);
    step(32'h5A00_0000, 1, 0);
    step(32'h1E00_0001, 1, 0);
    check("ovf.cmd_err", 32'(cmd_err), 32'd1);
    check("ovf.rej_cnt", 32'(rej_cnt), 32'd3);
    check("ovf.pending", 32'(pending), 32'd1);
    step(32'h0, 0, 0);
    check("ovf.cmd_err_low", 32'(cmd_err), 32'd0);
    step(32'h0, 0, 1);                // edge f
    step(32'h0, 0, 0);                // f+1: APPLY entered
    step(32'h1E00_0001, 1, 0);        // f+2: first pop, push accepted while full
    check("apply.fg_first", 32'(fg_rgb),  32'hABC);
    check("apply.push_ok",  32'(cmd_err), 32'd0);
    check("apply.rej_hold", 32'(rej_cnt), 32'd3);
    repeat (3) step(32'h0, 0, 0);
    check("apply.bg",      32'(bg_rgb),  32'h456);
    check("apply.pattern", 32'(pattern), 32'd2);
    check("apply.blank",   32'(blank),   32'd0);
    check("apply.mode",    32'(mode),    32'd0);
    check("apply.pending", 32'(pending), 32'd1);
    repeat (3) step(32'h0, 0, 0);
    check("late.mode_wait", 32'(mode), 32'd0);
    step(32'h0, 0, 1);
    step(32'h0, 0, 0);
    step(32'h0, 0, 0);
    check("late.mode",     32'(mode),     32'd1);
    check("late.mode_chg", 32'(mode_chg), 32'd1);
    check("late.pending",  32'(pending),  32'd0);
    step(32'h0, 0, 0);
    check("late.chg_low",  32'(mode_chg), 32'd0);

    // Reject counter saturation: 3 + 260 rejects stops at 8'hFF.
    for (int i = 0; i < 260; i++) step(32'hFFFF_FFFF, 1, 0);
    check("sat.rej_cnt", 32'(rej_cnt), 32'hFF);
    check("sat.cmd_err", 32'(cmd_err), 32'd1);
    step(32'h0, 0, 0);
    check("sat.rej_hold", 32'(rej_cnt), 32'hFF);

    // Reset after 2 of 4 entries are applied.
    step(32'h2D00_0111, 1, 0);
    step(32'h3C00_0222, 1, 0);
    step(32'h4B00_0003, 1, 0);
    step(32'h5A00_0001, 1, 0);
    step(32'h0, 0, 1);
    step(32'h0, 0, 0);
    step(32'h0, 0, 0);
    step(32'h0, 0, 0);
    check("mid.fg", 32'(fg_rgb), 32'h111);
    check("mid.bg", 32'(bg_rgb), 32'h222);
    sys_rst_n = 1'b0;
    #2;
    check_outs("mid_rst", rst_o);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step(32'h0, 0, 0);
    step(32'h0, 0, 1);
    repeat (6) step(32'h0, 0, 0);
    check_outs("post_rst", rst_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
